regfile_wb_arbiter: RTL and testbench

- Write-side front end of the 32x32 register file.
- Merges single-cycle ALU results and long-latency multiply/divide/load (MDU) results into the one register-file write port (write_ena/Rdc/Rd).
- MDU results are buffered in a small FIFO.
- Keeps a pending-register scoreboard so decode can stall on operands whose long-latency result has not yet been written back.

---
 rtl/regfile_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter for ALU and buffered MDU results
//
// Merges single-cycle ALU results and FIFO-buffered long-latency MDU results
// onto the single register-file write port, and tracks which registers still
// wait on a long-latency result so decode can stall on them.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   ena                        block enable; 0 freezes all state and blocks handshakes
//   alu_valid/rdc/data/ready   ALU result stream (ready is combinational)
//   mdu_valid/rdc/data/ready   MDU result stream into the FIFO (ready is registered)
//   claim_valid, claim_rdc     mark a register pending at long-latency issue
//   rsc, rtc, rs_busy, rt_busy decode operand lookups against the pending set
//   write_ena, Rdc, Rd         registered register-file write port
//   fifo_count                 MDU FIFO occupancy
module regfile_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rdc,
  input  logic [31:0]             alu_data,
  output logic                    alu_ready,
  input  logic                    mdu_valid,
  input  logic [4:0]              mdu_rdc,
  input  logic [31:0]             mdu_data,
  output logic                    mdu_ready,
  input  logic                    claim_valid,
  input  logic [4:0]              claim_rdc,
  input  logic [4:0]              rsc,
  input  logic [4:0]              rtc,
  output logic                    rs_busy,
  output logic                    rt_busy,
  output logic                    write_ena,
  output logic [4:0]              Rdc,
  output logic [31:0]             Rd,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (STARVE > 2) ? $clog2(STARVE) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] AGE_MAX  = GW'(STARVE - 1);

  typedef enum logic {
    ALU_PRI = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [GW-1:0] age_q, age_d;
  logic          room_q;
  logic [31:0]   pend_q, pend_d;
  logic          we_q, we_d;
  logic [4:0]    rdc_q, rdc_d;
  logic [31:0]   rd_q, rd_d;

  // Each entry is {rdc, data}.
  logic [36:0]   mem_q [DEPTH];
  logic [36:0]   head;

  logic          fifo_empty;
  logic          alu_wr;
  logic          push;
  logic          pop;

  always_comb begin
    head       = mem_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    alu_ready  = ena && (state_q == ALU_PRI);
    mdu_ready  = room_q && ena;
    // rdc=0 transfers complete the handshake but are dropped here.
    alu_wr     = alu_valid && alu_ready && (alu_rdc != 5'd0);
    push       = mdu_valid && mdu_ready && (mdu_rdc != 5'd0);
    // alu_ready is low in DRAIN, so alu_wr alone decides who owns the port.
    pop        = ena && !fifo_empty && !alu_wr;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    age_d    = age_q;
    pend_d   = pend_q;
    we_d     = 1'b0;
    rdc_d    = rdc_q;
    rd_d     = rd_q;

    if (ena) begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase

      if (pop || fifo_empty) begin
        age_d = '0;
      end else if (age_q != AGE_MAX) begin
        age_d = age_q + GW'(1);
      end

      case (state_q)
        ALU_PRI: begin
          if (!fifo_empty && !pop && ((count_q == CNT_FULL) || (age_q == AGE_MAX))) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (pop) state_d = ALU_PRI;
        end
        default: state_d = ALU_PRI;
      endcase

      if (alu_wr) begin
        we_d  = 1'b1;
        rdc_d = alu_rdc;
        rd_d  = alu_data;
      end else if (pop) begin
        we_d  = 1'b1;
        rdc_d = head[36:32];
        rd_d  = head[31:0];
        pend_d[head[36:32]] = 1'b0;
      end

      // Applied after the clear so a same-cycle claim keeps the bit set.
      if (claim_valid) pend_d[claim_rdc] = 1'b1;
      pend_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ALU_PRI;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      age_q    <= '0;
      room_q   <= 1'b0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      rdc_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      age_q    <= age_d;
      room_q   <= (count_d < CNT_FULL);
      pend_q   <= pend_d;
      we_q     <= we_d;
      rdc_q    <= rdc_d;
      rd_q     <= rd_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {mdu_rdc, mdu_data};
  end

  assign rs_busy    = (rsc != 5'd0) && pend_q[rsc];
  assign rt_busy    = (rtc != 5'd0) && pend_q[rtc];
  assign write_ena  = we_q;
  assign Rdc        = rdc_q;
  assign Rd         = rd_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rdc = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rdc = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic        claim_valid = 1'b0;
  logic [4:0]  claim_rdc = '0;
  logic [4:0]  rsc = '0;
  logic [4:0]  rtc = '0;
  logic        rs_busy;
  logic        rt_busy;
  logic        write_ena;
  logic [4:0]  Rdc;
  logic [31:0] Rd;
  logic [2:0]  fifo_count;

  regfile_wb_arbiter #(.DEPTH(4), .STARVE(8)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .alu_valid(alu_valid), .alu_rdc(alu_rdc), .alu_data(alu_data), .alu_ready(alu_ready),
    .mdu_valid(mdu_valid), .mdu_rdc(mdu_rdc), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .claim_valid(claim_valid), .claim_rdc(claim_rdc),
    .rsc(rsc), .rtc(rtc), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .write_ena(write_ena), .Rdc(Rdc), .Rd(Rd), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        cv;
    logic [4:0]  cr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_rsb;
    logic        e_rtb;
    logic        e_we;
    logic [4:0]  e_rdc;
    logic [31:0] e_rd;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        sb_on = 1'b0;
  logic [36:0] alu_q[$];
  logic [36:0] mdu_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no entry expected one", name);
  endtask

  task automatic add(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic cv, input logic [4:0] cr, input logic [4:0] rs_i,
                     input logic [4:0] rt_i, input logic e_rsb, input logic e_rtb,
                     input logic e_we, input logic [4:0] e_rdc, input logic [31:0] e_rd,
                     input logic [2:0] e_cnt);
    tbl.push_back({av, ar, ad, mv, mr, md, cv, cr, rs_i, rt_i, e_rsb, e_rtb, e_we, e_rdc, e_rd, e_cnt});
  endtask

  // One clock: record accepted transfers, cross the edge, check any write.
  task automatic step();
    logic [36:0] e;
    #1;
    if (sb_on) begin
      if (alu_valid && alu_ready && alu_rdc != 5'd0) alu_q.push_back({alu_rdc, alu_data});
      if (mdu_valid && mdu_ready && mdu_rdc != 5'd0) mdu_q.push_back({mdu_rdc, mdu_data});
    end
    @(posedge clk);
    #1;
    if (sb_on && write_ena) begin
      if (Rdc < 5'd16) begin
        if (mdu_q.size() == 0) fail("mdu_wr_order");
        else begin
          e = mdu_q.pop_front();
          chk("mdu_wr_rdc", 32'(Rdc), 32'(e[36:32]));
          chk("mdu_wr_data", Rd, e[31:0]);
        end
      end else begin
        if (alu_q.size() == 0) fail("alu_wr_order");
        else begin
          e = alu_q.pop_front();
          chk("alu_wr_rdc", 32'(Rdc), 32'(e[36:32]));
          chk("alu_wr_data", Rd, e[31:0]);
        end
      end
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; mdu_valid = 1'b0; claim_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int found;
    int drains;
    int guard;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(write_ena), 0);
    chk("rst_cnt", 32'(fifo_count), 0);
    chk("rst_mdu_ready", 32'(mdu_ready), 0);
    chk("rst_rdc", 32'(Rdc), 0);
    chk("rst_rd", Rd, 0);
    #3 rst = 1'b1;
    #1 chk("rel_mdu_ready0", 32'(mdu_ready), 0);
    @(posedge clk);
    #1 chk("rel_mdu_ready1", 32'(mdu_ready), 1);

    //   av    ar     ad            mv    mr     md            cv    cr    rs     rt     rsb   rtb   we    rdc    rd            cnt
    add(1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd0);
    add(1'b1, 5'd0,  32'h1,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9,  5'd9,  1'b0, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h1234,     1'b0, 5'd0, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF, 3'd1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  1'b1, 1'b1, 1'b1, 5'd9,  32'h1234,     3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9,  5'd9,  1'b0, 1'b0, 1'b0, 5'd9,  32'h1234,     3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd0,  1'b0, 1'b0, 1'b0, 5'd9,  32'h1234,     3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77,       1'b0, 5'd0, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 5'd9,  32'h1234,     3'd1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  32'h77,       3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  1'b1, 1'b0, 1'b0, 5'd7,  32'h77,       3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 5'd7,  32'h77,       3'd0);
    add(1'b1, 5'd4,  32'h44,       1'b1, 5'd3,  32'h33,       1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd4,  32'h44,       3'd1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd3,  32'h33,       3'd0);
    add(1'b1, 5'd11, 32'hB0,       1'b1, 5'd10, 32'hA0,       1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd11, 32'hB0,       3'd1);
    add(1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hC0,       1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd10, 32'hA0,       3'd1);
    add(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd12, 32'hC0,       3'd0);
    add(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFF,       1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd12, 32'hC0,       3'd0);

    foreach (tbl[i]) begin
      alu_valid = tbl[i].av; alu_rdc = tbl[i].ar; alu_data = tbl[i].ad;
      mdu_valid = tbl[i].mv; mdu_rdc = tbl[i].mr; mdu_data = tbl[i].md;
      claim_valid = tbl[i].cv; claim_rdc = tbl[i].cr;
      rsc = tbl[i].rs; rtc = tbl[i].rt;
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 1);
      chk($sformatf("v%0d_mdu_ready", i), 32'(mdu_ready), 1);
      chk($sformatf("v%0d_rs_busy", i), 32'(rs_busy), 32'(tbl[i].e_rsb));
      chk($sformatf("v%0d_rt_busy", i), 32'(rt_busy), 32'(tbl[i].e_rtb));
      step();
      chk($sformatf("v%0d_we", i), 32'(write_ena), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_rdc", i), 32'(Rdc), 32'(tbl[i].e_rdc));
      chk($sformatf("v%0d_rd", i), Rd, tbl[i].e_rd);
      chk($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
    end
    idle();
    rsc = '0; rtc = '0;

    // Full FIFO forces a single DRAIN cycle under constant ALU pressure.
    sb_on = 1'b1;
    alu_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      alu_rdc = 5'(16 + c); alu_data = 32'hA000_0000 + c;
      mdu_valid = (c < 4); mdu_rdc = 5'(1 + c); mdu_data = 32'h100 + c;
      #1;
      if (c == 4) begin
        chk("full_mdu_ready", 32'(mdu_ready), 0);
        chk("full_alu_ready", 32'(alu_ready), 1);
      end
      if (c == 5) chk("drain_alu_ready", 32'(alu_ready), 0);
      if (c == 6) chk("resume_alu_ready", 32'(alu_ready), 1);
      step();
      if (c == 3) chk("full_cnt", 32'(fifo_count), 4);
      if (c == 5) begin
        chk("drain_we", 32'(write_ena), 1);
        chk("drain_rdc", 32'(Rdc), 1);
        chk("drain_rd", Rd, 32'h100);
      end
      if (c == 6) chk("resume_rdc", 32'(Rdc), 22);
    end
    mdu_valid = 1'b0;
    guard = 0;
    while (mdu_q.size() != 0 && guard < 80) begin
      alu_rdc = 5'(16 + (guard % 8)); alu_data = 32'hB000_0000 + guard;
      step();
      guard++;
    end
    chk("full_all_drained", mdu_q.size(), 0);
    alu_valid = 1'b0;
    step();
    chk("full_alu_done", alu_q.size(), 0);

    // Starvation: one entry waits 8 cycles then goes out via one DRAIN cycle.
    alu_valid = 1'b1; alu_rdc = 5'd30; alu_data = 32'hC0DE;
    mdu_valid = 1'b1; mdu_rdc = 5'd6; mdu_data = 32'h66;
    step();
    mdu_valid = 1'b0;
    found = 0; drains = 0;
    for (int k = 1; k <= 20; k++) begin
      alu_rdc = 5'(16 + (k % 8)); alu_data = 32'hD000_0000 + k;
      #1;
      if (!alu_ready) drains++;
      step();
      if (write_ena && Rdc == 5'd6) begin
        found = k;
        break;
      end
    end
    chk("starve_latency", found, 9);
    chk("starve_drain_cycles", drains, 1);
    alu_valid = 1'b0;
    step();

    // ena low mid-stream freezes everything.
    alu_valid = 1'b1; alu_rdc = 5'd20; alu_data = 32'hE0;
    mdu_valid = 1'b1; mdu_rdc = 5'd13; mdu_data = 32'h13;
    step();
    alu_rdc = 5'd21; alu_data = 32'hE1; mdu_rdc = 5'd14; mdu_data = 32'h14;
    step();
    ena = 1'b0; mdu_rdc = 5'd15; mdu_data = 32'h15;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ena0_alu_ready", 32'(alu_ready), 0);
      chk("ena0_mdu_ready", 32'(mdu_ready), 0);
      step();
      chk("ena0_we", 32'(write_ena), 0);
      chk("ena0_cnt", 32'(fifo_count), 2);
    end
    ena = 1'b1;
    idle();
    guard = 0;
    while (mdu_q.size() != 0 && guard < 10) begin
      step();
      guard++;
    end
    chk("ena_resume_drained", mdu_q.size(), 0);
    chk("ena_resume_cnt", 32'(fifo_count), 0);
    chk("ena_resume_alu_done", alu_q.size(), 0);
    sb_on = 1'b0;

    // Reset in the middle of a full FIFO with every register pending.
    for (int r = 1; r < 32; r++) begin
      claim_valid = 1'b1; claim_rdc = 5'(r);
      step();
    end
    claim_valid = 1'b0;
    alu_valid = 1'b1; alu_rdc = 5'd20; alu_data = 32'hF0;
    for (int c = 0; c < 4; c++) begin
      mdu_valid = 1'b1; mdu_rdc = 5'(1 + c); mdu_data = 32'h200 + c;
      step();
    end
    idle();
    rsc = 5'd31; rtc = 5'd1;
    #1;
    chk("pre_rst_cnt", 32'(fifo_count), 4);
    chk("pre_rst_rs_busy", 32'(rs_busy), 1);
    chk("pre_rst_rt_busy", 32'(rt_busy), 1);
    chk("pre_rst_we", 32'(write_ena), 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(write_ena), 0);
    chk("mid_rst_cnt", 32'(fifo_count), 0);
    chk("mid_rst_rs_busy", 32'(rs_busy), 0);
    chk("mid_rst_rt_busy", 32'(rt_busy), 0);
    chk("mid_rst_mdu_ready", 32'(mdu_ready), 0);
    #2 rst = 1'b1;
    #1 chk("mid_rel_mdu_ready0", 32'(mdu_ready), 0);
    @(posedge clk);
    #1;
    chk("mid_rel_mdu_ready1", 32'(mdu_ready), 1);
    chk("mid_rel_rs_busy", 32'(rs_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
